// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit bus processor: widths, opcodes, step states.
package proc_pkg;

    localparam int BUS_W = 16;
    localparam int IR_W  = 9;
    localparam int NREG  = 8;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // True for the two opcodes that take the three-step ALU path.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; a disabled decoder outputs all zeros.
module dec3to8 (
    input  logic [2:0] w,
    input  logic       en,
    output logic [7:0] y
);

    // Decode the register index to a one-hot select.
    always_comb begin
        y = 8'h00;
        if (en) begin
            y = 8'h01 << w;
        end else begin
            y = 8'h00;
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Control unit for the bus processor: instruction register, T0..T3 step
// sequencer, and combinational bus-source / destination-enable decode.
module control_fsm
    import proc_pkg::*;
(
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [BUS_W-1:0]  DIN,
    output logic              IRIn,
    output logic [NREG-1:0]   ROut,
    output logic              GOut,
    output logic              DINOut,
    output logic [NREG-1:0]   RIn,
    output logic              AIn,
    output logic              GIn,
    output logic              AddSub,
    output logic              Done
);

    state_t            state;
    logic [IR_W-1:0]   ir;
    logic [2:0]        opcode;
    logic [NREG-1:0]   xreg;
    logic [NREG-1:0]   yreg;
    logic              din_low_unused;

    assign opcode = ir[8:6];

    // The immediate bits of DIN reach the registers through the bus mux, not here.
    assign din_low_unused = ^DIN[BUS_W-IR_W-1:0];

    dec3to8 u_dec_x (
        .w  (ir[5:3]),
        .en (1'b1),
        .y  (xreg)
    );

    dec3to8 u_dec_y (
        .w  (ir[2:0]),
        .en (1'b1),
        .y  (yreg)
    );

    // Instruction capture and step sequencing; reset aborts any instruction in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
            ir    <= 9'b0;
        end else begin
            if (IRIn) begin
                ir <= DIN[BUS_W-1:BUS_W-IR_W];
            end
            case (state)
                T0:      state <= Run  ? T1 : T0;
                T1:      state <= Done ? T0 : T2;
                T2:      state <= T3;
                T3:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

    // Per-step output decode; only one bus source is ever enabled, and all
    // outputs are held low while reset is asserted.
    always_comb begin
        IRIn   = 1'b0;
        ROut   = 8'h00;
        GOut   = 1'b0;
        DINOut = 1'b0;
        RIn    = 8'h00;
        AIn    = 1'b0;
        GIn    = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        if (Resetn) begin
            case (state)
                T0: begin
                    IRIn = Run;
                end
                T1: begin
                    case (opcode)
                        OP_MV: begin
                            ROut = yreg;
                            RIn  = xreg;
                            Done = 1'b1;
                        end
                        OP_MVI: begin
                            DINOut = 1'b1;
                            RIn    = xreg;
                            Done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ROut = xreg;
                            AIn  = 1'b1;
                        end
                        default: begin
                            Done = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    if (is_alu_op(opcode)) begin
                        ROut   = yreg;
                        GIn    = 1'b1;
                        AddSub = (opcode == OP_SUB);
                    end else begin
                        ROut = 8'h00;
                    end
                end
                T3: begin
                    if (is_alu_op(opcode)) begin
                        GOut = 1'b1;
                        RIn  = xreg;
                        Done = 1'b1;
                    end else begin
                        GOut = 1'b0;
                    end
                end
                default: begin
                    IRIn = 1'b0;
                end
            endcase
        end else begin
            IRIn = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: a schedule-based reference model plus
// directed scenarios with hand-computed expectations, then random traffic.
module tb_control_fsm;

    logic        Clock;
    logic        Resetn;
    logic        Run;
    logic [15:0] DIN;
    logic        IRIn;
    logic [7:0]  ROut;
    logic        GOut;
    logic        DINOut;
    logic [7:0]  RIn;
    logic        AIn;
    logic        GIn;
    logic        AddSub;
    logic        Done;

    int n_checks;
    int n_fail;

    // Expected output vectors for the remaining steps of the current instruction.
    logic [22:0] sched_q[$];

    control_fsm dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .DIN    (DIN),
        .IRIn   (IRIn),
        .ROut   (ROut),
        .GOut   (GOut),
        .DINOut (DINOut),
        .RIn    (RIn),
        .AIn    (AIn),
        .GIn    (GIn),
        .AddSub (AddSub),
        .Done   (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [22:0] mk(input logic irin, input logic [7:0] rout,
                                       input logic gout, input logic dinout,
                                       input logic [7:0] rin, input logic ain,
                                       input logic gin, input logic addsub,
                                       input logic done);
        return {irin, rout, gout, dinout, rin, ain, gin, addsub, done};
    endfunction

    function automatic logic [22:0] actual();
        return {IRIn, ROut, GOut, DINOut, RIn, AIn, GIn, AddSub, Done};
    endfunction

    // Queue the output sequence the instruction must produce after its fetch.
    function automatic void push_sched(input logic [8:0] ins);
        logic [2:0] op;
        logic [7:0] xo;
        logic [7:0] yo;
        op = ins[8:6];
        xo = 8'd1 << ins[5:3];
        yo = 8'd1 << ins[2:0];
        if (op == 3'd0) begin
            sched_q.push_back(mk(1'b0, yo, 1'b0, 1'b0, xo, 1'b0, 1'b0, 1'b0, 1'b1));
        end else if (op == 3'd1) begin
            sched_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, xo, 1'b0, 1'b0, 1'b0, 1'b1));
        end else if (op == 3'd2 || op == 3'd3) begin
            sched_q.push_back(mk(1'b0, xo, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
            sched_q.push_back(mk(1'b0, yo, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, op[0], 1'b0));
            sched_q.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, xo, 1'b0, 1'b0, 1'b0, 1'b1));
        end else begin
            sched_q.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        end
    endfunction

    function automatic logic [22:0] expected();
        if (!Resetn) begin
            return 23'd0;
        end else if (sched_q.size() == 0) begin
            return mk(Run, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            return sched_q[0];
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advance the instruction schedule on each clock edge.
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sched_q.delete();
        end else if (sched_q.size() != 0) begin
            sched_q.delete(0);
        end else if (Run) begin
            push_sched(DIN[15:7]);
        end
    end

    // Compare every cycle against the model and check the bus invariant.
    always @(negedge Clock) begin
        chk("model", {9'd0, actual()}, {9'd0, expected()});
        chk("bus_invariant",
            {31'd0, ($onehot0(ROut) && ((32'(DINOut) + 32'(GOut) + 32'(|ROut)) <= 32'd1))},
            32'd1);
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Resetn   = 1'b0;
        Run      = 1'b1;
        DIN      = 16'hFFFF;

        // Reset with Run high: everything low, including IRIn.
        #1;
        chk("reset_all_zero", {9'd0, actual()}, 32'd0);
        tick();
        tick();
        chk("reset_hold_zero", {9'd0, actual()}, 32'd0);

        // Release with Run low: idle in T0.
        Resetn = 1'b1;
        Run    = 1'b0;
        DIN    = 16'h0000;
        @(negedge Clock);
        chk("idle_zero", {9'd0, actual()}, 32'd0);
        tick();
        chk("idle_done", {31'd0, Done}, 32'd0);

        // mvi R2,#0x00A5
        Run = 1'b1;
        DIN = 16'b001_010_000_0000000;
        @(negedge Clock);
        chk("mvi_t0_irin", {31'd0, IRIn}, 32'd1);
        tick();
        Run = 1'b0;
        DIN = 16'h00A5;
        @(negedge Clock);
        chk("mvi_t1_dinout", {31'd0, DINOut}, 32'd1);
        chk("mvi_t1_rin", {24'd0, RIn}, 32'h04);
        chk("mvi_t1_done", {31'd0, Done}, 32'd1);
        tick();
        @(negedge Clock);
        chk("mvi_back_t0", {9'd0, actual()}, 32'd0);

        // mv R5,R2
        tick();
        Run = 1'b1;
        DIN = {9'b000_101_010, 7'd0};
        tick();
        Run = 1'b0;
        @(negedge Clock);
        chk("mv_t1", {9'd0, actual()}, {9'd0, mk(1'b0, 8'h04, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1)});

        // sub R1,R7: Done three edges after fetch
        tick();
        Run = 1'b1;
        DIN = {9'b011_001_111, 7'd0};
        tick();
        Run = 1'b0;
        @(negedge Clock);
        chk("sub_t1", {9'd0, actual()}, {9'd0, mk(1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0)});
        tick();
        chk("sub_t2", {9'd0, actual()}, {9'd0, mk(1'b0, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0)});
        tick();
        chk("sub_t3", {9'd0, actual()}, {9'd0, mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1)});

        // add R0,R3 aborted by reset in T2
        tick();
        Run = 1'b1;
        DIN = {9'b010_000_011, 7'd0};
        tick();
        Run = 1'b0;
        tick();
        chk("add_t2_gin", {31'd0, GIn}, 32'd1);
        Resetn = 1'b0;
        #1;
        chk("abort_zero", {9'd0, actual()}, 32'd0);
        tick();
        Resetn = 1'b1;
        @(negedge Clock);
        chk("abort_idle", {9'd0, actual()}, 32'd0);
        tick();
        chk("abort_no_done", {31'd0, Done}, 32'd0);

        // Two NOPs (opcode 110) with Run held high
        Run = 1'b1;
        DIN = {9'b110_000_000, 7'd0};
        @(negedge Clock);
        chk("nop_fetch1", {31'd0, IRIn}, 32'd1);
        tick();
        chk("nop_t1", {9'd0, actual()}, {9'd0, mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1)});
        tick();
        chk("nop_fetch2", {9'd0, actual()}, {9'd0, mk(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)});
        tick();
        chk("nop_t1_second", {31'd0, Done}, 32'd1);
        Run = 1'b0;
        tick();

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if (!Resetn) begin
                Resetn = 1'b1;
            end else if ($urandom_range(0, 150) == 0) begin
                Resetn = 1'b0;
            end else begin
                Resetn = 1'b1;
            end
            Run = ($urandom_range(0, 3) != 0);
            DIN = 16'($urandom);
            tick();
        end

        @(negedge Clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Sequential control unit for the 16-bit bus processor. Each instruction word on DIN is captured into an internal instruction register. The unit then runs a T0–T3 step sequence and drives the bus-source selects (ROut, GOut, DINOut) that feed the bus multiplexer, plus the destination enables (RIn, AIn, GIn), the ALU mode (AddSub) and Done.

## Interface
Parameters:
- None. Widths are fixed by the datapath: 16-bit bus, 9-bit instruction, 8 registers.

Ports:
- Clock    in   1    system clock; all state changes on its rising edge
- Resetn   in   1    asynchronous, active-low reset
- Run      in   1    start request; sampled only in T0
- DIN      in   16   external data/instruction bus; DIN[15:7] is the instruction III XXX YYY
- IRIn     out  1    instruction-register load strobe (also observable externally)
- ROut     out  8    one-hot register source select R0..R7 (bit n = Rn); 0 = none
- GOut     out  1    G register drives the bus
- DINOut   out  1    DIN drives the bus
- RIn      out  8    one-hot register write enable R0..R7
- AIn      out  1    A register load
- GIn      out  1    G register load
- AddSub   out  1    0 = add, 1 = subtract
- Done     out  1    instruction complete this cycle

## Operation
- IR (9 bits) loads DIN[15:7] on the Clock edge where IRIn=1.
- Fields: III = IR[8:6], X = IR[5:3], Y = IR[2:0]. X and Y are decoded one-hot to Xreg[7:0] and Yreg[7:0].
- Opcodes:
  - 000 mv  Rx←Ry
  - 001 mvi Rx←DIN
  - 010 add Rx←Rx+Ry
  - 011 sub Rx←Rx−Ry
  - 100–111 are NOP: Done only, no register written.
- States T0, T1, T2, T3 (2-bit). Transitions:
  - T0→T1 if Run=1, else hold in T0.
  - T1→T0 if Done=1, else T1→T2.
  - T2→T3.
  - T3→T0.
- Outputs are combinational from state, IR and Run. Any output not listed for a state/opcode is 0.
  - T0: IRIn=Run.
  - T1, mv: ROut=Yreg, RIn=Xreg, Done=1.
  - T1, mvi: DINOut=1, RIn=Xreg, Done=1.
  - T1, add/sub: ROut=Xreg, AIn=1.
  - T1, NOP: Done=1.
  - T2, add: ROut=Yreg, GIn=1.
  - T2, sub: ROut=Yreg, GIn=1, AddSub=1.
  - T3, add/sub: GOut=1, RIn=Xreg, Done=1.
- Bus invariant: at most one of {DINOut, GOut, |ROut} is active in any cycle, and ROut is one-hot or zero. The bus mux gives DINOut priority, but this unit never relies on that priority.
- X=Y is legal (for example add R3,R3 doubles R3). No special case.

## Timing
- Reset (Resetn=0, asynchronous): state=T0, IR=9'b0. While Resetn=0, every output is forced to 0, including IRIn regardless of Run.
- Reset mid-instruction aborts it immediately; no Done is issued. After release, the unit sits in T0.
- Latency, counted from the Run=1 edge in T0 to Done:
  - mv, mvi, NOP: Done in T1, 2 cycles per instruction including T0.
  - add, sub: Done in T3, 4 cycles.
- Run is ignored in T1–T3. Run held high causes back-to-back instructions, each starting with a fresh T0 fetch.
- DIN must hold the instruction during the T0 edge, and the immediate during T1 for mvi.
- Done is high for exactly one cycle per instruction.

## Structure
- Shared package `proc_pkg`:
  - opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011
  - state encodings T0=2'd0, T1=2'd1, T2=2'd2, T3=2'd3
  - widths BUS_W=16, IR_W=9, NREG=8
- Sub-module `dec3to8`: 3-bit in, 8-bit one-hot out, with an enable input. Instantiated twice, for X and Y.
- Inside control_fsm: IR register, state register, and one combinational output process.

## Test plan
- Reset and idle: Resetn=0 with Run=1 → all outputs 0. Release with Run=0 → state stays T0, only IRIn=Run=0, no Done.
- mvi R2,#0x00A5: DIN=16'b001_010_000_0000000 at T0 with Run=1, then DIN=16'h00A5 → T1 shows DINOut=1, RIn=8'h04, Done=1. The next cycle is back in T0.
- mv R5,R2: instruction 000_101_010 → T1 shows ROut=8'h04, RIn=8'h20, Done=1. Assert bus invariant every cycle.
- sub R1,R7: instruction 011_001_111 →
  - T1: ROut=8'h02, AIn=1
  - T2: ROut=8'h80, GIn=1, AddSub=1
  - T3: GOut=1, RIn=8'h02, Done=1
  - Done rises exactly 3 cycles after the T0 edge.
- Reset mid-add: issue add R0,R3 and pull Resetn low during T2 → outputs 0 asynchronously, IR=0, no Done. After release, state is T0.
- NOP opcode 110 with Run held high across two instructions → Done in T1, no RIn/AIn/GIn. The second fetch's IRIn=1 appears in the cycle immediately after Done.
